// File: rtl/patch_pkg.sv
// Geometry constants and FSM state type shared by the patch sequencer files.
// Default image geometry lives here; modules derive their own widths from parameters.
package patch_pkg;

    localparam int DEF_CHANNEL_SIZE = 8;
    localparam int DEF_NUM_CHANNELS = 3;
    localparam int DEF_IMG_WIDTH    = 16;
    localparam int DEF_IMG_HEIGHT   = 16;
    localparam int DEF_PATCH_SIZE   = 4;

    localparam int PIXEL_WIDTH       = DEF_CHANNEL_SIZE * DEF_NUM_CHANNELS;
    localparam int PATCHES_IN_ROW    = DEF_IMG_WIDTH / DEF_PATCH_SIZE;
    localparam int PATCHES_IN_COL    = DEF_IMG_HEIGHT / DEF_PATCH_SIZE;
    localparam int TOTAL_NUM_PATCHES = PATCHES_IN_ROW * PATCHES_IN_COL;
    localparam int PATCH_VECTOR_SIZE = DEF_PATCH_SIZE * DEF_PATCH_SIZE;

    localparam int ROW_ADDR_W  = $clog2(DEF_IMG_HEIGHT);
    localparam int COL_ADDR_W  = $clog2(DEF_IMG_WIDTH);
    localparam int PATCH_IDX_W = $clog2(TOTAL_NUM_PATCHES);
    localparam int POS_IDX_W   = $clog2(PATCH_VECTOR_SIZE);
    localparam int PATCH_SHIFT = $clog2(DEF_PATCH_SIZE);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_DONE  = 3'd3
    } state_e;

endpackage

// File: rtl/patch_sequencer_if.sv
// Pixel output stream of the patch sequencer: valid/ready beat plus patch tags.
// master drives pix_valid/pix_data/patch_idx/pos_idx/patch_last/frame_last; slave drives pix_ready.
interface patch_sequencer_if #(
    parameter int DATA_W  = patch_pkg::PIXEL_WIDTH,
    parameter int PATCH_W = patch_pkg::PATCH_IDX_W,
    parameter int POS_W   = patch_pkg::POS_IDX_W
);

    logic               pix_valid;
    logic               pix_ready;
    logic [DATA_W-1:0]  pix_data;
    logic [PATCH_W-1:0] patch_idx;
    logic [POS_W-1:0]   pos_idx;
    logic               patch_last;
    logic               frame_last;

    modport master (
        output pix_valid,
        output pix_data,
        output patch_idx,
        output pos_idx,
        output patch_last,
        output frame_last,
        input  pix_ready
    );

    modport slave (
        input  pix_valid,
        input  pix_data,
        input  patch_idx,
        input  pos_idx,
        input  patch_last,
        input  frame_last,
        output pix_ready
    );

endinterface

// File: rtl/patch_skid_buf.sv
// Two-entry FIFO holding returned pixels with their tags; head is presented until popped.
// Ports: clk, reset, in_valid/in_data (push), out_valid/out_ready/out_data (pop), count.
module patch_skid_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    logic [1:0][WIDTH-1:0] mem_q, mem_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  pop;

    // Upstream never pushes into a full buffer unless the head leaves the
    // same cycle; then wr_ptr equals rd_ptr and the new beat takes the
    // slot being vacated, becoming the tail behind the other entry.
    always_comb begin
        pop      = out_ready && (cnt_q != 2'd0);
        mem_d    = mem_q;
        if (in_valid) begin
            mem_d[wr_ptr_q] = in_data;
        end
        wr_ptr_d = wr_ptr_q ^ in_valid;
        rd_ptr_d = rd_ptr_q ^ pop;
        cnt_d    = cnt_q + {1'b0, in_valid} - {1'b0, pop};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q    <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = mem_q[rd_ptr_q];
    assign count     = cnt_q;

endmodule

// File: rtl/patch_sequencer.sv
// Reads an image buffer in patch-major order and streams tagged pixels out.
// Ports: clk, reset, start, output_taken, rd_en/rd_row/rd_col/rd_data, pix (stream), state;
// stall_cnt exists only when PATCHSEQ_PERF_CNT_EN is defined.
module patch_sequencer
    import patch_pkg::*;
#(
    parameter int CHANNEL_SIZE = DEF_CHANNEL_SIZE,
    parameter int NUM_CHANNELS = DEF_NUM_CHANNELS,
    parameter int IMG_WIDTH    = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT   = DEF_IMG_HEIGHT,
    parameter int PATCH_SIZE   = DEF_PATCH_SIZE
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic                                 output_taken,
    output logic                                 rd_en,
    output logic [$clog2(IMG_HEIGHT)-1:0]        rd_row,
    output logic [$clog2(IMG_WIDTH)-1:0]         rd_col,
    input  logic [CHANNEL_SIZE*NUM_CHANNELS-1:0] rd_data,
    patch_sequencer_if.master                    pix,
    output logic [2:0]                           state
`ifdef PATCHSEQ_PERF_CNT_EN
    ,
    output logic [31:0]                          stall_cnt
`endif
);

    localparam int PIX_W   = CHANNEL_SIZE * NUM_CHANNELS;
    localparam int ROW_W   = $clog2(IMG_HEIGHT);
    localparam int COL_W   = $clog2(IMG_WIDTH);
    localparam int SHIFT   = $clog2(PATCH_SIZE);
    localparam int PROW_N  = IMG_WIDTH / PATCH_SIZE;
    localparam int PCOL_N  = IMG_HEIGHT / PATCH_SIZE;
    localparam int NPATCH  = PROW_N * PCOL_N;
    localparam int NPOS    = PATCH_SIZE * PATCH_SIZE;
    localparam int PATCH_W = $clog2(NPATCH);
    localparam int POS_W   = $clog2(NPOS);
    localparam int META_W  = PATCH_W + POS_W + 2;
    localparam int BUF_W   = PIX_W + META_W;

    state_e             state_q, state_d;
    logic [PATCH_W-1:0] patch_q, patch_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic [COL_W-1:0]   pcol_q, pcol_d;
    logic [ROW_W-1:0]   prow_q, prow_d;
    logic               inflight_q, inflight_d;
    logic [META_W-1:0]  meta_q, meta_d;

    logic               last_pos;
    logic               last_col;
    logic               last_patch;
    logic               start_frame;
    logic               pop;
    logic [2:0]         occ;
    logic [1:0]         buf_cnt;
    logic               buf_valid;
    logic [BUF_W-1:0]   buf_data;

    // The beat leaving this cycle frees its slot, so subtracting it from
    // the occupancy lets a read issue every cycle while the consumer keeps up.
    always_comb begin
        start_frame = (state_q == ST_IDLE) && start;
        pop         = buf_valid && pix.pix_ready;
        occ         = 3'(buf_cnt) + 3'(inflight_q) - 3'(pop);
        last_pos    = (pos_q == POS_W'(NPOS - 1));
        last_col    = (pcol_q == COL_W'(PROW_N - 1));
        last_patch  = (patch_q == PATCH_W'(NPATCH - 1));
        rd_en       = (state_q == ST_RUN) && (occ < 3'd2);
    end

    // Patch row/column are kept as separate counters so the address is
    // built from shifts and masks even when the patch grid is not 2^n wide.
    always_comb begin
        patch_d = patch_q;
        pos_d   = pos_q;
        pcol_d  = pcol_q;
        prow_d  = prow_q;
        if (start_frame) begin
            patch_d = '0;
            pos_d   = '0;
            pcol_d  = '0;
            prow_d  = '0;
        end else if (rd_en) begin
            pos_d = last_pos ? '0 : pos_q + 1'b1;
            if (last_pos) begin
                patch_d = last_patch ? '0 : patch_q + 1'b1;
                pcol_d  = last_col ? '0 : pcol_q + 1'b1;
                if (last_col) begin
                    prow_d = last_patch ? '0 : prow_q + 1'b1;
                end
            end
        end
    end

    assign rd_row = (prow_q << SHIFT) | ROW_W'(pos_q >> SHIFT);
    assign rd_col = (pcol_q << SHIFT)
                  | COL_W'(pos_q & POS_W'(PATCH_SIZE - 1));

    // Tags travel alongside the read so they join rd_data one cycle later.
    always_comb begin
        inflight_d = rd_en;
        meta_d     = meta_q;
        if (rd_en) begin
            meta_d = {patch_q, pos_q, last_pos, last_pos && last_patch};
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start) state_d = ST_RUN;
            ST_RUN:   if (rd_en && last_pos && last_patch) state_d = ST_DRAIN;
            ST_DRAIN: if (pop && pix.frame_last) state_d = ST_DONE;
            ST_DONE:  if (output_taken) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            patch_q    <= '0;
            pos_q      <= '0;
            pcol_q     <= '0;
            prow_q     <= '0;
            inflight_q <= 1'b0;
            meta_q     <= '0;
        end else begin
            state_q    <= state_d;
            patch_q    <= patch_d;
            pos_q      <= pos_d;
            pcol_q     <= pcol_d;
            prow_q     <= prow_d;
            inflight_q <= inflight_d;
            meta_q     <= meta_d;
        end
    end

    patch_skid_buf #(
        .WIDTH (BUF_W)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (inflight_q),
        .in_data   ({rd_data, meta_q}),
        .out_valid (buf_valid),
        .out_ready (pix.pix_ready),
        .out_data  (buf_data),
        .count     (buf_cnt)
    );

    assign pix.pix_valid = buf_valid;
    assign {pix.pix_data, pix.patch_idx, pix.pos_idx,
            pix.patch_last, pix.frame_last} = buf_data;
    assign state = state_q;

`ifdef PATCHSEQ_PERF_CNT_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (start_frame) begin
            stall_d = '0;
        end else if (buf_valid && !pix.pix_ready && (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_patch_sequencer.sv
// Self-checking bench for patch_sequencer: ramp image, scoreboard of expected beats,
// table of spot checks, stall/reset/restart sequences. Honours PATCHSEQ_PERF_CNT_EN.
module tb_patch_sequencer;
    import patch_pkg::*;

    localparam int NB = TOTAL_NUM_PATCHES * PATCH_VECTOR_SIZE;
    localparam int SW = PIXEL_WIDTH + PATCH_IDX_W + POS_IDX_W + 2;

    typedef struct {
        logic [PIXEL_WIDTH-1:0] pix;
        int                     patch;
        int                     pos;
        bit                     plast;
        bit                     flast;
    } exp_t;

    typedef struct {
        int beat;
        int patch;
        int pos;
        int pix;
        bit plast;
        bit flast;
    } vec_t;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   start;
    logic                   output_taken;
    logic                   rd_en;
    logic [ROW_ADDR_W-1:0]  rd_row;
    logic [COL_ADDR_W-1:0]  rd_col;
    logic [PIXEL_WIDTH-1:0] rd_data = '0;
    logic [2:0]             state;
`ifdef PATCHSEQ_PERF_CNT_EN
    logic [31:0]            stall_cnt;
`endif

    patch_sequencer_if pix_if ();

    patch_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .output_taken (output_taken),
        .rd_en        (rd_en),
        .rd_row       (rd_row),
        .rd_col       (rd_col),
        .rd_data      (rd_data),
        .pix          (pix_if),
        .state        (state)
`ifdef PATCHSEQ_PERF_CNT_EN
        ,
        .stall_cnt    (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Ramp image buffer with one cycle of read latency.
    always @(posedge clk) begin
        if (rd_en) begin
            rd_data <= PIXEL_WIDTH'(int'(rd_row) * DEF_IMG_WIDTH + int'(rd_col));
        end
    end

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            beat = 0;
    int            rd_total = 0;
    int            first_cyc = 0;
    int            last_cyc = 0;
    exp_t          sb[$];
    logic          hold = 1'b0;
    logic [SW-1:0] snap = '0;
    int            cap_pix[NB];
    int            cap_patch[NB];
    int            cap_pos[NB];
    bit            cap_pl[NB];
    bit            cap_fl[NB];
    vec_t          tbl[8];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic exp_t model(input int b);
        exp_t e;
        int   p, q, row, col;
        p       = b / PATCH_VECTOR_SIZE;
        q       = b % PATCH_VECTOR_SIZE;
        row     = (p / PATCHES_IN_ROW) * DEF_PATCH_SIZE + q / DEF_PATCH_SIZE;
        col     = (p % PATCHES_IN_ROW) * DEF_PATCH_SIZE + q % DEF_PATCH_SIZE;
        e.pix   = PIXEL_WIDTH'(row * DEF_IMG_WIDTH + col);
        e.patch = p;
        e.pos   = q;
        e.plast = (q == PATCH_VECTOR_SIZE - 1);
        e.flast = (b == NB - 1);
        return e;
    endfunction

    task automatic load_frame();
        sb.delete();
        for (int b = 0; b < NB; b++) sb.push_back(model(b));
        beat = 0;
    endtask

    // Output monitor: runs once per cycle at the falling edge.
    task automatic sample();
        logic [SW-1:0] cur;
        exp_t          e;
        if (reset) begin
            hold = 1'b0;
            return;
        end
        cur = {pix_if.pix_data, pix_if.patch_idx, pix_if.pos_idx,
               pix_if.patch_last, pix_if.frame_last};
        if (hold) begin
            chk("stall_valid", 64'(pix_if.pix_valid), 64'd1);
            chk("stall_hold", 64'(cur), 64'(snap));
        end
        if (pix_if.pix_valid && pix_if.pix_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_beat got %0h want none", cur);
            end else begin
                e = sb.pop_front();
                chk($sformatf("beat%0d", beat), 64'(cur),
                    64'({e.pix, PATCH_IDX_W'(e.patch), POS_IDX_W'(e.pos),
                         e.plast, e.flast}));
            end
            if (beat < NB) begin
                cap_pix[beat]   = int'(pix_if.pix_data);
                cap_patch[beat] = int'(pix_if.patch_idx);
                cap_pos[beat]   = int'(pix_if.pos_idx);
                cap_pl[beat]    = pix_if.patch_last;
                cap_fl[beat]    = pix_if.frame_last;
            end
            if (beat == 0) first_cyc = cyc;
            last_cyc = cyc;
            beat++;
        end
        hold = pix_if.pix_valid && !pix_if.pix_ready;
        snap = cur;
        if (rd_en) rd_total++;
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_done(input bit rnd, input int budget);
        for (int i = 0; i < budget && state != 3'd3; i++) begin
            if (rnd) pix_if.pix_ready = 1'($urandom_range(0, 1));
            tick();
        end
        pix_if.pix_ready = 1'b1;
        chk("done_reached", 64'(state), 64'd3);
    endtask

    task automatic frame_checks(input string nm);
        chk({nm, "_beats"}, 64'(beat), 64'(NB));
        chk({nm, "_sb_empty"}, 64'(sb.size()), 64'd0);
    endtask

    task automatic release_done();
        output_taken = 1'b1;
        tick();
        output_taken = 1'b0;
        chk("done_to_idle", 64'(state), 64'd0);
    endtask

    int st;
    int rb;

    initial begin
        tbl[0] = '{0,   0,  0,  0,   0, 0};
        tbl[1] = '{5,   0,  5,  17,  0, 0};
        tbl[2] = '{15,  0,  15, 51,  1, 0};
        tbl[3] = '{16,  1,  0,  4,   0, 0};
        tbl[4] = '{20,  1,  4,  20,  0, 0};
        tbl[5] = '{100, 6,  4,  88,  0, 0};
        tbl[6] = '{250, 15, 10, 238, 0, 0};
        tbl[7] = '{255, 15, 15, 255, 1, 1};

        reset            = 1'b1;
        start            = 1'b0;
        output_taken     = 1'b0;
        pix_if.pix_ready = 1'b1;
        repeat (3) tick();
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_rd_en", 64'(rd_en), 64'd0);
        chk("rst_rd_row", 64'(rd_row), 64'd0);
        chk("rst_rd_col", 64'(rd_col), 64'd0);
        chk("rst_valid", 64'(pix_if.pix_valid), 64'd0);
        chk("rst_data", 64'(pix_if.pix_data), 64'd0);
        chk("rst_patch", 64'(pix_if.patch_idx), 64'd0);
        chk("rst_pos", 64'(pix_if.pos_idx), 64'd0);
        chk("rst_plast", 64'(pix_if.patch_last), 64'd0);
        chk("rst_flast", 64'(pix_if.frame_last), 64'd0);
        reset = 1'b0;
        tick();

        // Full-rate frame; start kept high to show it is ignored mid-frame.
        load_frame();
        start = 1'b1;
        tick();
        st = cyc;
        wait_done(1'b0, 400);
        frame_checks("a");
        chk("first_latency", 64'(first_cyc - st), 64'd2);
        chk("burst_span", 64'(last_cyc - first_cyc), 64'(NB - 1));
        for (int i = 0; i < 8; i++) begin
            rb = tbl[i].beat;
            chk($sformatf("tbl%0d_pix", i), 64'(cap_pix[rb]), 64'(tbl[i].pix));
            chk($sformatf("tbl%0d_patch", i), 64'(cap_patch[rb]),
                64'(tbl[i].patch));
            chk($sformatf("tbl%0d_pos", i), 64'(cap_pos[rb]), 64'(tbl[i].pos));
            chk($sformatf("tbl%0d_plast", i), 64'(cap_pl[rb]),
                64'(tbl[i].plast));
            chk($sformatf("tbl%0d_flast", i), 64'(cap_fl[rb]),
                64'(tbl[i].flast));
        end
        repeat (4) tick();
        chk("done_hold", 64'(state), 64'd3);
        chk("done_no_rd", 64'(rd_en), 64'd0);
        start = 1'b0;
        release_done();

        // Random back-pressure.
        load_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(1'b1, 2000);
        frame_checks("b");
        release_done();

        // Consumer stalled for the first 21 cycles of the frame.
        pix_if.pix_ready = 1'b0;
        load_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
        rb = rd_total;
        repeat (21) tick();
        chk("rd_en_stalled", 64'(rd_total - rb), 64'd2);
        chk("stall_valid_hi", 64'(pix_if.pix_valid), 64'd1);
        pix_if.pix_ready = 1'b1;
        wait_done(1'b0, 400);
        frame_checks("c");
`ifdef PATCHSEQ_PERF_CNT_EN
        chk("stall_cnt", 64'(stall_cnt), 64'd19);
`endif
        release_done();

        // Reset in the middle of a frame, then a clean frame.
        load_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 400 && beat < 101; i++) tick();
        chk("mid_beats", 64'(beat), 64'd101);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb.delete();
        chk("mid_rst_state", 64'(state), 64'd0);
        chk("mid_rst_valid", 64'(pix_if.pix_valid), 64'd0);
        chk("mid_rst_rd_en", 64'(rd_en), 64'd0);
        repeat (3) tick();
        chk("mid_idle_valid", 64'(pix_if.pix_valid), 64'd0);
        load_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(1'b0, 400);
        frame_checks("d");
        chk("d_first_patch", 64'(cap_patch[0]), 64'd0);
        chk("d_first_pos", 64'(cap_pos[0]), 64'd0);
        chk("d_first_pix", 64'(cap_pix[0]), 64'd0);
        release_done();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/patch_sequencer.md
PATCH_SEQUENCER -- requirements
Module: patch_sequencer

Interface
REQ-001 Parameter CHANNEL_SIZE, 8, bits per colour channel.
REQ-002 Parameter NUM_CHANNELS, 3, channels per pixel; PIXEL_WIDTH = CHANNEL_SIZE*NUM_CHANNELS.
REQ-003 Parameter IMG_WIDTH, 16, image columns; parameter IMG_HEIGHT, 16, image rows.
REQ-004 Parameter PATCH_SIZE, 4, patch edge in pixels; power of two dividing IMG_WIDTH and IMG_HEIGHT.
REQ-005 clk  input  1  single clock; all logic on posedge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 start  input  1  begin one frame; sampled only in IDLE.
REQ-008 output_taken  input  1  consumer acknowledges frame completion; sampled only in DONE.
REQ-009 rd_en  output  1  image-buffer read strobe.
REQ-010 rd_row  output  clog2(IMG_HEIGHT)  read row address.
REQ-011 rd_col  output  clog2(IMG_WIDTH)  read column address.
REQ-012 rd_data  input  PIXEL_WIDTH  pixel returned exactly 1 cycle after rd_en.
REQ-013 pix_valid / pix_ready  output / input  1 each  output-stream handshake; beat transfers when both high.
REQ-014 pix_data  output  PIXEL_WIDTH  pixel of current beat.
REQ-015 patch_idx  output  clog2(TOTAL_NUM_PATCHES)  patch of current beat; pos_idx  output  clog2(PATCH_SIZE^2)  position in patch.
REQ-016 patch_last  output  1  beat is last position of its patch; frame_last  output  1  beat is last of frame.
REQ-017 state  output  3  FSM state encoding (IDLE=0, RUN=1, DRAIN=2, DONE=3).

Function
REQ-018 Beat order SHALL be patch-major: patch_idx 0..TOTAL_NUM_PATCHES-1 raster over patch grid, pos_idx 0..PATCH_SIZE^2-1 row-major inside patch.
REQ-019 Address for (patch_idx p, pos_idx q) SHALL be rd_row=(p/PATCHES_IN_ROW)*PATCH_SIZE+q/PATCH_SIZE, rd_col=(p%PATCHES_IN_ROW)*PATCH_SIZE+q%PATCH_SIZE, computed by shifts/masks only.
REQ-020 IDLE->RUN when start=1; start in any other state SHALL be ignored.
REQ-021 RUN: rd_en asserted in a cycle only if (buffered beats + reads in flight) < 2; address counter advances on each rd_en.
REQ-022 RUN->DRAIN in the cycle after the final address is issued; no rd_en in DRAIN, DONE, IDLE.
REQ-023 DRAIN->DONE the cycle after the frame_last beat transfers; DONE->IDLE when output_taken=1.
REQ-024 Returned data, patch_idx, pos_idx, patch_last, frame_last SHALL be held in a 2-entry skid buffer; pix_* outputs stable while pix_valid=1 and pix_ready=0.
REQ-025 No beat dropped or duplicated under any pix_ready pattern; with pix_ready held 1, throughput SHALL be one beat per cycle, first beat pix_valid 2 cycles after start sampled.
REQ-026 Buffer full with read in flight cannot occur (REQ-021); simultaneous push and pop on full buffer SHALL be legal.

Reset
REQ-027 reset SHALL force state=IDLE, rd_en=0, rd_row=rd_col=0, pix_valid=0, pix_data=0, patch_idx=pos_idx=0, patch_last=frame_last=0, counters and buffer cleared.
REQ-028 reset mid-frame SHALL discard any in-flight read and buffered beats; next frame restarts at patch 0, position 0.

Configuration
REQ-029 Macro PATCHSEQ_PERF_CNT_EN defined: output stall_cnt (32 bits) counts cycles with pix_valid=1 and pix_ready=0, cleared on reset and on IDLE->RUN, saturating at all-ones.
REQ-030 Macro undefined: stall_cnt port and counter SHALL not exist; all other behaviour identical.

Structure
REQ-031 Shared package patch_pkg SHALL hold geometry constants (PIXEL_WIDTH, PATCHES_IN_ROW, TOTAL_NUM_PATCHES, PATCH_VECTOR_SIZE, log2 widths) and the FSM state enum.
REQ-032 Skid buffer SHALL be sub-module patch_skid_buf (2 entries, parameterised payload width); FSM and address generation stay in patch_sequencer.

Verification
REQ-033 Default params, pix_ready=1, ramp image (pixel=row*16+col): 256 beats in 256 consecutive cycles; beat 5 = patch 0 pos 5 = pixel (1,1)=17; beat 16 = pixel (0,4)=4.
REQ-034 Random pix_ready (50%): all 256 beats in order, patch_last on every 16th beat, frame_last only on beat 255, outputs stable during stalls.
REQ-035 pix_ready=0 for 20 cycles after start: exactly 2 rd_en pulses, then none until ready rises; with PATCHSEQ_PERF_CNT_EN, stall_cnt=19 (pix_valid high from cycle 2, ready low through cycle 20).
REQ-036 reset pulse after beat 100 then start: first beat is patch 0 pos 0, no stale data emitted.
REQ-037 start asserted in RUN/DRAIN/DONE ignored; DONE held until output_taken=1, then IDLE next cycle and a new start produces a full 256-beat frame.
